// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with arbitrary depth, first-word-fall-through
// head, registered occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow error flags.
module fifo_level #(
  parameter int DWIDTH   = 8,
  parameter int FDEPTH   = 5,
  parameter int AF_LEVEL = FDEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CWIDTH  = $clog2(FDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              write_i,
  input  logic              read_i,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CWIDTH-1:0] count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  // Pointers only ever hold 0..FDEPTH-1, so clog2(FDEPTH) bits suffice.
  localparam int PWIDTH = $clog2(FDEPTH);

  localparam logic [PWIDTH-1:0] PTR_LAST = PWIDTH'(FDEPTH - 1);
  localparam logic [CWIDTH-1:0] CNT_FULL = CWIDTH'(FDEPTH);
  localparam logic [CWIDTH-1:0] CNT_AF   = CWIDTH'(AF_LEVEL);
  localparam logic [CWIDTH-1:0] CNT_AE   = CWIDTH'(AE_LEVEL);

  // Storage array; deliberately not reset so it maps onto plain memory.
  logic [DWIDTH-1:0] mem [FDEPTH];

  logic [PWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CWIDTH-1:0] count_reg, count_next;
  logic              full_reg, full_next;
  logic              empty_reg, empty_next;
  logic              af_reg, af_next;
  logic              ae_reg, ae_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;

  logic rd_acc;
  logic wr_acc;
  logic mem_we;

  // Acceptance: a read needs data; a write needs room, or a same-cycle read
  // that frees the slot (a full FIFO is never empty, so that read is accepted).
  always_comb begin
    rd_acc = read_i && !empty_reg;
    wr_acc = write_i && (!full_reg || read_i);
    mem_we = wr_acc && !flush_i;
  end

  // Next-state: flush overrides traffic; flags are derived from the next count
  // so they are always consistent with count_o in the same cycle.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    udf_next    = udf_reg;

    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      ovf_next    = 1'b0;
      udf_next    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_next = count_reg + CWIDTH'(wr_acc) - CWIDTH'(rd_acc);
      ovf_next   = ovf_reg || (write_i && !wr_acc);
      udf_next   = udf_reg || (read_i && !rd_acc);
    end

    full_next  = (count_next == CNT_FULL);
    empty_next = (count_next == '0);
    af_next    = (count_next >= CNT_AF);
    ae_next    = (count_next <= CNT_AE);
  end

  // Control state register with asynchronous reset to the empty condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      af_reg     <= af_next;
      ae_reg     <= ae_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

  // Storage write port; flush suppresses a concurrent write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  // Head of queue falls through combinationally from the registered pointer.
  always_comb begin
    data_o         = mem[rd_ptr_reg];
    full_o         = full_reg;
    empty_o        = empty_reg;
    almost_full_o  = af_reg;
    almost_empty_o = ae_reg;
    count_o        = count_reg;
    overflow_o     = ovf_reg;
    underflow_o    = udf_reg;
  end

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed test of fifo_level with default parameters
// (FDEPTH=5, AF_LEVEL=4, AE_LEVEL=1); expected values are hand-computed.
module tb_fifo_level;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       write_i;
  logic       read_i;
  logic       flush_i;
  logic [7:0] data_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_tests;
  int n_fail;

  fifo_level dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .write_i        (write_i),
    .read_i         (read_i),
    .flush_i        (flush_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare count and all level/error flags against expected values.
  task automatic check_state(input string tag, input int c, input bit e, input bit ae,
                             input bit af, input bit f, input bit ovf, input bit udf);
    check_eq({tag, ".count"}, 32'(count_o), 32'(c));
    check_eq({tag, ".empty"}, 32'(empty_o), 32'(e));
    check_eq({tag, ".aempty"}, 32'(almost_empty_o), 32'(ae));
    check_eq({tag, ".afull"}, 32'(almost_full_o), 32'(af));
    check_eq({tag, ".full"}, 32'(full_o), 32'(f));
    check_eq({tag, ".ovf"}, 32'(overflow_o), 32'(ovf));
    check_eq({tag, ".udf"}, 32'(underflow_o), 32'(udf));
  endtask

  // One transaction: apply inputs, clock once, settle, return to idle.
  task automatic xact(input bit wr, input bit rd, input bit fl, input logic [7:0] d);
    write_i = wr;
    read_i  = rd;
    flush_i = fl;
    data_i  = d;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t wr=%b rd=%b fl=%b din=%02h -> count=%0d head=%02h ovf=%b udf=%b",
             $time, wr, rd, fl, d, count_o, data_o, overflow_o, underflow_o);
    write_i = 1'b0;
    read_i  = 1'b0;
    flush_i = 1'b0;
    data_i  = 8'h00;
  endtask

  // Level flag tables for filling an empty FIFO one entry at a time.
  int exp_cnt  [5] = '{1, 2, 3, 4, 5};
  bit exp_ae   [5] = '{1, 0, 0, 0, 0};
  bit exp_af   [5] = '{0, 0, 0, 1, 1};
  bit exp_full [5] = '{0, 0, 0, 0, 1};
  logic [7:0] drain4 [5] = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h66};

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    flush_i = 1'b0;
    data_i  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Fill 0x11..0x15 and watch the level flags step.
    for (int i = 0; i < 5; i++) begin
      xact(1, 0, 0, 8'(8'h11 + i));
      check_state($sformatf("fill%0d", i), exp_cnt[i], 0, exp_ae[i], exp_af[i], exp_full[i], 0, 0);
      check_eq($sformatf("fill%0d.head", i), 32'(data_o), 32'h11);
    end

    // Write into a full FIFO: rejected, overflow sticks, head unchanged.
    xact(1, 0, 0, 8'hAA);
    check_state("ovf", 5, 0, 0, 1, 1, 1, 0);
    check_eq("ovf.head", 32'(data_o), 32'h11);
    xact(0, 0, 0, 8'h00);
    check_eq("ovf.sticky", 32'(overflow_o), 32'd1);

    // Drain in order.
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("drain%0d.data", i), 32'(data_o), 32'(8'h11 + i));
      xact(0, 1, 0, 8'h00);
    end
    check_state("drained", 0, 1, 1, 0, 0, 1, 0);

    // Read from empty: underflow; then write+read on empty keeps the write.
    xact(0, 1, 0, 8'h00);
    check_state("udf", 0, 1, 1, 0, 0, 1, 1);
    xact(1, 1, 0, 8'h33);
    check_state("wr_rd_empty", 1, 0, 1, 0, 0, 1, 1);
    check_eq("wr_rd_empty.data", 32'(data_o), 32'h33);

    // Flush with count 3, both errors set and a concurrent write.
    xact(1, 0, 0, 8'h34);
    xact(1, 0, 0, 8'h35);
    check_eq("preflush.count", 32'(count_o), 32'd3);
    xact(1, 0, 1, 8'h99);
    check_state("flush", 0, 1, 1, 0, 0, 0, 0);
    xact(1, 0, 0, 8'h44);
    check_eq("postflush.count", 32'(count_o), 32'd1);
    check_eq("postflush.data", 32'(data_o), 32'h44);
    xact(0, 1, 0, 8'h00);
    check_eq("postflush.empty", 32'(empty_o), 32'd1);

    // Full FIFO with simultaneous write+read: both proceed.
    for (int i = 0; i < 5; i++) xact(1, 0, 0, 8'(8'h51 + i));
    check_state("full2", 5, 0, 0, 1, 1, 0, 0);
    check_eq("full2.head", 32'(data_o), 32'h51);
    xact(1, 1, 0, 8'h66);
    check_state("full_wr_rd", 5, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("drain4_%0d.data", i), 32'(data_o), 32'(drain4[i]));
      xact(0, 1, 0, 8'h00);
    end
    check_state("drained4", 0, 1, 1, 0, 0, 0, 0);

    // Wrap: 4 rounds of 3 writes then 3 reads.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        xact(1, 0, 0, 8'(8'h70 + r * 3 + j));
        check_eq($sformatf("wrap%0d_w%0d.count", r, j), 32'(count_o), 32'(j + 1));
      end
      for (int j = 0; j < 3; j++) begin
        check_eq($sformatf("wrap%0d_r%0d.data", r, j), 32'(data_o), 32'(8'h70 + r * 3 + j));
        xact(0, 1, 0, 8'h00);
      end
      check_eq($sformatf("wrap%0d.empty", r), 32'(empty_o), 32'd1);
    end

    // Asynchronous reset mid-burst clears everything without a clock edge.
    xact(0, 1, 0, 8'h00);
    xact(1, 0, 0, 8'hC1);
    xact(1, 0, 0, 8'hC2);
    check_state("preburst", 2, 0, 0, 0, 0, 0, 1);
    write_i = 1'b1;
    data_i  = 8'hC3;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 1, 1, 0, 0, 0, 0);
    write_i = 1'b0;
    @(posedge clk);
    #1;
    check_state("in_rst", 0, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
